// File: rtl/pulse_train_generator_if.sv
// ---------------------------------------------------------------------------
// pulse_train_generator_if
// Groups the request and waveform signals of pulse_train_generator.
//
// Optional feature macro: PULSE_TRAIN_GENERATOR_ABORT_EN adds the abort line.
//
// Signals (direction given from the master, i.e. the requester, side):
//   start        out  request to launch a pulse train
//   high_cycles  out  N-bit high-phase length in clk cycles
//   low_cycles   out  N-bit low-phase length in clk cycles
//   num_pulses   out  N-bit number of high/low periods
//   abort        out  cancel a running train (only with the macro defined)
//   out          in   generated waveform
//   busy         in   train in progress
//   done         in   one-cycle completion strobe
// ---------------------------------------------------------------------------
interface pulse_train_generator_if #(
    parameter int N = 8
);
    logic         start;
    logic [N-1:0] high_cycles;
    logic [N-1:0] low_cycles;
    logic [N-1:0] num_pulses;
`ifdef PULSE_TRAIN_GENERATOR_ABORT_EN
    logic         abort;
`endif
    logic         out;
    logic         busy;
    logic         done;

    modport master (
`ifdef PULSE_TRAIN_GENERATOR_ABORT_EN
        output abort,
`endif
        output start, high_cycles, low_cycles, num_pulses,
        input  out, busy, done
    );

    modport slave (
`ifdef PULSE_TRAIN_GENERATOR_ABORT_EN
        input  abort,
`endif
        input  start, high_cycles, low_cycles, num_pulses,
        output out, busy, done
    );
endinterface

// File: rtl/pulse_train_generator.sv
// ---------------------------------------------------------------------------
// pulse_train_generator
// Moore FSM that produces num_pulses periods of high_cycles high followed by
// low_cycles low, then a one-cycle done strobe. Zero phase lengths count as 1.
// Parameters are captured when start is accepted in S_IDLE, so later changes
// on the inputs do not disturb a train in progress.
//
// Optional feature macro: PULSE_TRAIN_GENERATOR_ABORT_EN
//   When defined, bus.abort high in S_HIGH/S_LOW returns the FSM to S_IDLE
//   without a done strobe.
//
// Ports:
//   clk  in   single clock, rising edge
//   rst  in   synchronous active-high reset
//   bus  slave modport of pulse_train_generator_if (start, lengths, count,
//        optional abort in; out, busy, done out)
// ---------------------------------------------------------------------------
module pulse_train_generator #(
    parameter int N = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    pulse_train_generator_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [N-1:0] ZERO = {N{1'b0}};
    localparam logic [N-1:0] ONE  = {{(N-1){1'b0}}, 1'b1};

    state_t       state_r;
    state_t       state_next_s;
    logic [N-1:0] h_r;             // effective high length, always >= 1 once latched
    logic [N-1:0] l_r;             // effective low length, always >= 1 once latched
    logic [N-1:0] p_r;             // number of periods
    logic [N-1:0] phase_cnt_r;     // cycles already spent in the current phase
    logic [N-1:0] period_cnt_r;    // periods already completed
    logic [N-1:0] phase_len_s;
    logic         phase_last_s;
    logic         period_last_s;
    logic         accept_s;
    logic         abort_s;
    logic         out_s;
    logic         busy_s;
    logic         done_s;

`ifdef PULSE_TRAIN_GENERATOR_ABORT_EN
    assign abort_s = bus.abort;
`else
    assign abort_s = 1'b0;
`endif

    // Counters compare against length-1 so that a length of 2^N-1 never
    // needs a counter value beyond 2^N-2.
    assign accept_s      = (state_r == S_IDLE) && bus.start;
    assign phase_len_s   = (state_r == S_LOW) ? l_r : h_r;
    assign phase_last_s  = (phase_cnt_r == (phase_len_s - ONE));
    assign period_last_s = (period_cnt_r == (p_r - ONE));

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next_s = S_IDLE;
        case (state_r)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.num_pulses == ZERO) begin
                        state_next_s = S_DONE;
                    end else begin
                        state_next_s = S_HIGH;
                    end
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_HIGH: begin
                if (abort_s) begin
                    state_next_s = S_IDLE;
                end else if (phase_last_s) begin
                    state_next_s = S_LOW;
                end else begin
                    state_next_s = S_HIGH;
                end
            end
            S_LOW: begin
                if (abort_s) begin
                    state_next_s = S_IDLE;
                end else if (phase_last_s) begin
                    if (period_last_s) begin
                        state_next_s = S_DONE;
                    end else begin
                        state_next_s = S_HIGH;
                    end
                end else begin
                    state_next_s = S_LOW;
                end
            end
            S_DONE: begin
                state_next_s = S_IDLE;
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase
    end

    // Parameter capture and phase/period counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_r          <= ZERO;
            l_r          <= ZERO;
            p_r          <= ZERO;
            phase_cnt_r  <= ZERO;
            period_cnt_r <= ZERO;
        end else if (accept_s) begin
            h_r          <= (bus.high_cycles == ZERO) ? ONE : bus.high_cycles;
            l_r          <= (bus.low_cycles == ZERO) ? ONE : bus.low_cycles;
            p_r          <= bus.num_pulses;
            phase_cnt_r  <= ZERO;
            period_cnt_r <= ZERO;
        end else if ((state_r == S_HIGH) || (state_r == S_LOW)) begin
            if (phase_last_s) begin
                phase_cnt_r <= ZERO;
                // A period completes at the end of its low phase.
                if (state_r == S_LOW) begin
                    period_cnt_r <= period_cnt_r + ONE;
                end else begin
                    period_cnt_r <= period_cnt_r;
                end
            end else begin
                phase_cnt_r  <= phase_cnt_r + ONE;
                period_cnt_r <= period_cnt_r;
            end
        end else begin
            phase_cnt_r  <= ZERO;
            period_cnt_r <= ZERO;
        end
    end

    // Moore output decode from the state register.
    always_comb begin
        out_s  = 1'b0;
        busy_s = 1'b0;
        done_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                out_s  = 1'b0;
                busy_s = 1'b0;
                done_s = 1'b0;
            end
            S_HIGH: begin
                out_s  = 1'b1;
                busy_s = 1'b1;
            end
            S_LOW: begin
                busy_s = 1'b1;
            end
            S_DONE: begin
                done_s = 1'b1;
            end
            default: begin
                out_s  = 1'b0;
                busy_s = 1'b0;
                done_s = 1'b0;
            end
        endcase
    end

    assign bus.out  = out_s;
    assign bus.busy = busy_s;
    assign bus.done = done_s;

endmodule
